// File: rtl/timer_dev_pkg.sv
// Shared definitions for the timer_dev programmable countdown timer:
// register map, CTRL bit layout, MODE encodings and FSM state codes.
package timer_dev_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_RSVD   = 2'd3;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_CNT  = 2'd2;
   localparam logic [1:0] ST_INT  = 2'd3;

   // Packed so that the struct maps directly onto CTRL bits [3:0]
   typedef struct packed {
      logic       im;
      logic [1:0] mode;
      logic       en;
   } ctrl_t;

   // Only 01 reloads; 00 and both 1x codes behave as one-shot
   function automatic logic mode_is_reload(input logic [1:0] mode);
      return mode == MODE_RELOAD;
   endfunction

endpackage

// File: rtl/timer_dev.sv
// Bus-programmable 32-bit countdown timer with one-shot and auto-reload modes.
// irq is intended for HWInt[2] of the CPU interrupt bus.
module timer_dev
   import timer_dev_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              irq
);

   ctrl_t             ctrl;
   logic [DATA_W-1:0] preset;
   logic [DATA_W-1:0] count;
   logic              irq_flag;
   logic [1:0]        state;
   logic [1:0]        state_next;

   logic wr_ctrl;
   logic wr_preset;
   logic at_zero;
   logic reload;
   logic fire;

   assign wr_ctrl   = we && (addr == ADDR_CTRL);
   assign wr_preset = we && (addr == ADDR_PRESET);
   assign at_zero   = (count == '0);
   assign reload    = mode_is_reload(ctrl.mode);
   assign fire      = (state == ST_CNT) && ctrl.en && at_zero;

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (ctrl.en) state_next = ST_LOAD;
         ST_LOAD: state_next = ST_CNT;
         ST_CNT: begin
            if (!ctrl.en)    state_next = ST_IDLE;
            else if (at_zero) state_next = ST_INT;
         end
         ST_INT:  state_next = reload ? ST_LOAD : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ctrl     <= '0;
         preset   <= '0;
         count    <= '0;
         irq_flag <= 1'b0;
      end else begin
         state <= state_next;

         // A software CTRL write overrides the one-shot EN clear in INT
         if (wr_ctrl) begin
            ctrl.en   <= din[CTRL_EN];
            ctrl.mode <= din[CTRL_MODE_HI:CTRL_MODE_LO];
            ctrl.im   <= din[CTRL_IM];
         end else if ((state == ST_INT) && !reload) begin
            ctrl.en <= 1'b0;
         end

         if (wr_preset) preset <= din;

         if (state == ST_LOAD)
            count <= preset;
         else if ((state == ST_CNT) && ctrl.en && !at_zero)
            count <= count - DATA_W'(1);

         // Register writes acknowledge the interrupt, even against a same-edge set
         if (wr_ctrl || wr_preset)
            irq_flag <= 1'b0;
         else if (fire)
            irq_flag <= 1'b1;
         else if ((state == ST_INT) && reload)
            irq_flag <= 1'b0;
      end
   end

   always_comb begin
      dout = '0;
      case (addr)
         ADDR_CTRL:   dout = {{(DATA_W-4){1'b0}}, ctrl};
         ADDR_PRESET: dout = preset;
         ADDR_COUNT:  dout = count;
         ADDR_RSVD:   dout = '0;
         default:     dout = '0;
      endcase
   end

   assign irq = irq_flag & ctrl.im;

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 we  input  1  bus write strobe for the register selected by addr.
REQ-004 addr  input  2  word address [3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 din  input  32  bus write data.
REQ-006 dout  output  32  combinational read data for the register selected by addr.
REQ-007 irq  output  1  interrupt request; drives one bit of the CPU HWInt[7:2] bus.

Function
REQ-008 CTRL SHALL hold EN at bit 0, MODE at bits [2:1], and IM at bit 3; all other bits SHALL read 0.
REQ-009 MODE encodings SHALL be: 00 = one-shot; 01 = auto-reload; 1x = treated as one-shot.
REQ-010 PRESET SHALL be a 32-bit read/write register.
REQ-011 COUNT SHALL be a 32-bit read-only register; writes to addr 2 or 3 SHALL be ignored.
REQ-012 A read of addr 3 SHALL return 0.
REQ-013 The FSM SHALL have four states: IDLE, LOAD, CNT, INT.
REQ-014 IDLE: if EN=1, go to LOAD; otherwise stay, and COUNT holds.
REQ-015 LOAD: COUNT <= PRESET; go to CNT.
REQ-016 CNT, EN=0: go to IDLE; COUNT holds.
REQ-017 CNT, EN=1, COUNT != 0: COUNT <= COUNT-1.
REQ-018 CNT, EN=1, COUNT == 0: go to INT and set irq_flag in the same edge.
REQ-019 INT, one-shot mode: clear EN; go to IDLE; irq_flag stays set.
REQ-020 INT, auto-reload mode: go to LOAD; irq_flag clears on leaving INT (one-cycle pulse).
REQ-021 irq SHALL equal irq_flag AND CTRL.IM; it is registered-state based, with no combinational path from din or we.
REQ-022 Any write to CTRL or PRESET SHALL clear irq_flag.
REQ-023 Timing: with PRESET=P written beforehand, irq SHALL first be high in the cycle following edge e0+P+3, where e0 is the edge that writes EN=1 (IM=1).
REQ-024 Auto-reload period SHALL be P+3 cycles between irq pulses.
REQ-025 PRESET=0 SHALL give INT exactly 3 edges after EN is written; no underflow.
REQ-026 COUNT SHALL never wrap below 0.
REQ-027 A PRESET write during CNT SHALL NOT affect the running COUNT; it takes effect at the next LOAD.
REQ-028 Simultaneous CTRL write and INT-state hardware EN clear: the software write SHALL win for all CTRL bits.
REQ-029 In the case of REQ-028, irq_flag SHALL be cleared (REQ-022 beats the set from REQ-018 in that edge).
REQ-030 Writing EN=0 during LOAD SHALL still complete the load; the FSM then goes IDLE from CNT on the next edge.
REQ-031 A MODE change mid-count SHALL take effect at the next INT evaluation.

Reset
REQ-032 On rst at a clock edge: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE.
REQ-033 In the cycle after a reset edge, irq SHALL be 0 and dout at addr 0/1/2 SHALL be 0.
REQ-034 rst asserted mid-count SHALL abort the count with no residual irq pulse.
REQ-035 rst SHALL take priority over we in the same edge.

Structure
REQ-036 Shared package SHALL contain: register address constants (CTRL, PRESET, COUNT), CTRL bit positions (EN, MODE, IM), MODE encodings, FSM state encoding.
REQ-037 Single module with no sub-module; the decrementer and register file are inline.
REQ-038 irq SHALL connect at SoC level to HWInt[2].

Verification
REQ-039 PRESET=5, CTRL=0x9 (EN, one-shot, IM) -> irq rises 8 cycles after the CTRL write edge and stays high; CTRL reads 0x8; COUNT reads 0.
REQ-040 PRESET=3, CTRL=0xB (auto-reload) -> one-cycle irq pulses every 6 cycles; COUNT sequence 3,2,1,0 repeats.
REQ-041 One-shot fired, irq high -> write CTRL=0x8 -> irq low next cycle; COUNT holds 0; state IDLE.
REQ-042 Counting with COUNT=10, write PRESET=2 -> current run continues from 10; next auto-reload loads 2.
REQ-043 rst asserted while COUNT=4 -> next cycle all registers read 0, irq=0, no later pulse without a rewrite of CTRL.
REQ-044 CTRL write in the same cycle the FSM is in INT (one-shot) -> CTRL equals written value, irq_flag=0.
